// File: rtl/rom_fifo_xfer_ctrl.sv
// ROM-to-FIFO transfer controller: reads xfer_len words starting at start_addr from a
// synchronous ROM and pushes each into a FIFO, one word every three cycles when not stalled.
module rom_fifo_xfer_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_mem,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   xfer_len,
    input  logic              fifo_full,
    input  logic [DATA_W-1:0] ROM_data,
    output logic              ROM_ce,
    output logic              ROM_re,
    output logic [ADDR_W-1:0] ROM_addr,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_sent
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   words_inc;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign words_inc = words_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        words_d    = words_q;
        wdata_d    = wdata_q;
        fifo_wr    = 1'b0;
        // restart wins over everything, including a write that would otherwise fire
        if (restart) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_addr_d = start_addr;
                        len_d      = xfer_len;
                        words_d    = '0;
                        state_d    = (xfer_len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    wdata_d = ROM_data;
                    state_d = WRITE;
                end
                WRITE: begin
                    if (!fifo_full) begin
                        fifo_wr    = 1'b1;
                        words_d    = words_inc;
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        state_d    = (words_inc == len_q) ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            words_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            words_q    <= words_d;
            wdata_q    <= wdata_d;
        end
    end

    assign ROM_ce     = (state_q == ISSUE) || (state_q == CAPTURE);
    assign ROM_re     = (state_q == ISSUE);
    assign ROM_addr   = cur_addr_q;
    assign fifo_wdata = wdata_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign words_sent = words_q;

endmodule

// File: tb/tb_rom_fifo_xfer_ctrl.sv
// Scoreboard bench for rom_fifo_xfer_ctrl: stimulus queues expected reads/writes/done,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_rom_fifo_xfer_ctrl;

    logic       clk_mem;
    logic       reset_n;
    logic       restart;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] xfer_len;
    logic       fifo_full;
    logic [7:0] ROM_data;
    logic       ROM_ce;
    logic       ROM_re;
    logic [3:0] ROM_addr;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic       busy;
    logic       done;
    logic [4:0] words_sent;

    logic full_force;
    logic rnd_full;
    logic rand_en;
    assign fifo_full = full_force | rnd_full;

    rom_fifo_xfer_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk_mem    (clk_mem),
        .reset_n    (reset_n),
        .restart    (restart),
        .start      (start),
        .start_addr (start_addr),
        .xfer_len   (xfer_len),
        .fifo_full  (fifo_full),
        .ROM_data   (ROM_data),
        .ROM_ce     (ROM_ce),
        .ROM_re     (ROM_re),
        .ROM_addr   (ROM_addr),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    typedef struct {
        logic [7:0] data;
        bit         first;
        int         start_cyc;
    } wr_t;

    typedef struct {
        int words;
        bit zero;
        int start_cyc;
    } done_t;

    wr_t   exp_wr[$];
    int    exp_rd[$];
    done_t exp_done[$];

    logic [7:0] mem [16];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int last_wr = 0;
    bit full_seen = 1'b0;

    initial clk_mem = 1'b0;
    always #5 clk_mem = ~clk_mem;

    always @(posedge clk_mem) cyc <= cyc + 1;

    // Synchronous ROM: data appears the cycle after a read is issued
    always @(posedge clk_mem) if (ROM_ce && ROM_re) ROM_data <= mem[ROM_addr];

    always @(posedge clk_mem) begin
        #1;
        rnd_full = rand_en && ($urandom_range(0, 3) == 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk_mem) begin
        if (reset_n && !restart) begin
            if (fifo_full) full_seen = 1'b1;
            if (ROM_re) begin
                chk("rom_ce_with_re", int'(ROM_ce), 1);
                if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
                else chk("rom_addr", int'(ROM_addr), exp_rd.pop_front());
            end
            if (fifo_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wdata", int'(fifo_wdata), int'(e.data));
                    if (!full_seen) begin
                        if (e.first) chk("first_wr_latency", cyc - e.start_cyc, 3);
                        else chk("wr_interval", cyc - last_wr, 3);
                    end
                    last_wr = cyc;
                    full_seen = 1'b0;
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done_words_sent", int'(words_sent), d.words);
                    chk("done_writes_left", exp_wr.size(), 0);
                    if (d.zero) chk("done_zero_len_time", cyc - d.start_cyc, 1);
                    else chk("done_after_last_wr", cyc - last_wr, 1);
                end
                full_seen = 1'b0;
            end
        end
    end

    task automatic flush();
        exp_wr.delete();
        exp_rd.delete();
        exp_done.delete();
    endtask

    // Called just after a clock edge while the DUT is idle
    task automatic do_start(input int a, input int n);
        wr_t   w;
        done_t d;
        for (int i = 0; i < n; i++) begin
            w.data = mem[(a + i) % 16];
            w.first = (i == 0);
            w.start_cyc = cyc;
            exp_wr.push_back(w);
            exp_rd.push_back((a + i) % 16);
        end
        d.words = n;
        d.zero = (n == 0);
        d.start_cyc = cyc;
        exp_done.push_back(d);
        start = 1'b1;
        start_addr = 4'(a);
        xfer_len = 5'(n);
        @(posedge clk_mem); #1;
        start = 1'b0;
        start_addr = 4'($urandom);
        xfer_len = 5'($urandom);
    endtask

    // Wait for idle, pulsing ignored start requests while busy when noisy
    task automatic wait_idle(input bit noisy);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_mem); #1;
            start = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (noisy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                start_addr = 4'($urandom);
                xfer_len = 5'($urandom);
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: busy still %0d, required 0", busy);
        end
    endtask

    initial begin
        int nw;
        reset_n = 1'b0;
        restart = 1'b0;
        start = 1'b0;
        start_addr = '0;
        xfer_len = '0;
        full_force = 1'b0;
        rand_en = 1'b0;
        rnd_full = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);

        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fifo_wr", int'(fifo_wr), 0);
        chk("rst_rom_ce", int'(ROM_ce), 0);
        chk("rst_rom_re", int'(ROM_re), 0);
        chk("rst_rom_addr", int'(ROM_addr), 0);
        chk("rst_wdata", int'(fifo_wdata), 0);
        chk("rst_words", int'(words_sent), 0);
        repeat (2) @(posedge clk_mem);
        #1 reset_n = 1'b1;
        @(posedge clk_mem); #1;

        // Basic 4-word transfer, then words_sent must hold
        do_start(0, 4);
        wait_idle(1'b0);
        repeat (3) @(posedge clk_mem);
        #1 chk("words_hold", int'(words_sent), 4);

        // Address wrap 14,15,0,1
        do_start(14, 4);
        wait_idle(1'b1);

        // Stall the second write for five cycles
        do_start(0, 4);
        repeat (5) @(posedge clk_mem);
        #1 full_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("stall_no_wr", int'(fifo_wr), 0);
            chk("stall_wdata", int'(fifo_wdata), 3);
            @(posedge clk_mem); #1;
        end
        full_force = 1'b0;
        wait_idle(1'b0);

        // Zero-length transfer
        do_start(5, 0);
        wait_idle(1'b0);
        chk("zero_len_words", int'(words_sent), 0);

        // Restart after the second write, then a single-word transfer
        do_start(0, 4);
        nw = 0;
        for (int i = 0; i < 50 && nw < 2; i++) begin
            @(posedge clk_mem); #1;
            if (fifo_wr) nw++;
        end
        chk("restart_saw_two_writes", nw, 2);
        @(posedge clk_mem); #1;
        restart = 1'b1;
        flush();
        @(posedge clk_mem); #1;
        restart = 1'b0;
        chk("restart_busy", int'(busy), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_words", int'(words_sent), 2);
        do_start(8, 1);
        wait_idle(1'b0);

        // Restart landing on a WRITE cycle must suppress the strobe
        do_start(3, 2);
        repeat (2) @(posedge clk_mem);
        #1 restart = 1'b1;
        flush();
        #2 chk("restart_blocks_wr", int'(fifo_wr), 0);
        @(posedge clk_mem); #1;
        restart = 1'b0;
        chk("restart2_busy", int'(busy), 0);
        chk("restart2_words", int'(words_sent), 0);

        // Asynchronous reset in CAPTURE
        @(posedge clk_mem); #1;
        do_start(5, 4);
        @(posedge clk_mem); #2;
        reset_n = 1'b0;
        flush();
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_rom_ce", int'(ROM_ce), 0);
        chk("arst_fifo_wr", int'(fifo_wr), 0);
        chk("arst_rom_addr", int'(ROM_addr), 0);
        chk("arst_wdata", int'(fifo_wdata), 0);
        chk("arst_words", int'(words_sent), 0);
        #1 reset_n = 1'b1;
        @(posedge clk_mem); #1;
        do_start(0, 4);
        wait_idle(1'b0);

        // Randomized transfers with random back-pressure and ignored start noise
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        rand_en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            do_start($urandom_range(0, 15), $urandom_range(0, 16));
            wait_idle(1'b1);
        end
        rand_en = 1'b0;

        repeat (5) @(posedge clk_mem);
        #1 chk("leftover_expectations", exp_wr.size() + exp_rd.size() + exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
